// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/shift_add_mult_rca.sv
// N-bit ripple-carry adder; Carry exposes the carry out of every bit position.
module RCA_nb #(
  parameter int n = 4
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Sum,
  output logic         Cout,
  output logic [n-1:0] Carry
);

  logic [n:0] chain;

  always_comb begin
    chain    = '0;
    Sum      = '0;
    chain[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      Sum[i]     = A[i] ^ B[i] ^ chain[i];
      chain[i+1] = (A[i] & B[i]) | (A[i] & chain[i]) | (B[i] & chain[i]);
    end
  end

  assign Carry = chain[n:1];
  assign Cout  = chain[n];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential N x N unsigned multiplier: one ripple-carry add and right shift per clock.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           Start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           Busy,
  output logic           Done,
  output logic [2*N-1:0] Product
);

  localparam int CW = $clog2(N);

  mult_state_t    state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N-1:0]   add;
  logic [N-1:0]   s;
  logic           c;
  logic [N-1:0]   carry_unused;
  logic [2*N-1:0] shifted;

  // Partial product for this pass is the multiplicand gated by the current multiplier LSB.
  assign add     = lo_q[0] ? mcand_q : '0;
  assign shifted = {c, s, lo_q[N-1:1]};

  RCA_nb #(.n(N)) u_rca (
    .A     (hi_q),
    .B     (add),
    .Sum   (s),
    .Cout  (c),
    .Carry (carry_unused)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = CALC;
          mcand_d = A;
          lo_d    = B;
          hi_d    = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        hi_d = shifted[2*N-1:N];
        lo_d = shifted[N-1:0];
        // Counter saturates at N-1; the last pass also commits the result.
        if (cnt_q == CW'(N - 1)) begin
          state_d   = DONE;
          product_d = shifted;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);
  assign Product = product_q;

endmodule
